// File: rtl/pll_ctrl_pkg.sv
// Shared definitions for the PLL lock sequencer: FSM state encoding, loss counter width, clog2.
package pll_ctrl_pkg;

  localparam int LOSS_W = 8;

  typedef enum logic [2:0] {
    ST_RESET_PLL = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } state_t;

  // Bits needed to hold the values 0..n-1; returns 0 for n <= 1.
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pll_lock_sequencer_if.sv
// PLL-side and system-side signals of the lock sequencer; master is the sequencer, slave the environment.
interface pll_lock_sequencer_if #(
  parameter int RETRY_W = 2
);
  import pll_ctrl_pkg::*;

  logic               pll_lock;
  logic               restart;
  logic               pll_reset;
  logic               sys_rst;
  logic               locked_ok;
  logic               fail;
  logic [RETRY_W-1:0] retry_cnt;
  logic [LOSS_W-1:0]  loss_cnt;

  modport master (
    input  pll_lock, restart,
    output pll_reset, sys_rst, locked_ok, fail, retry_cnt, loss_cnt
  );

  modport slave (
    output pll_lock, restart,
    input  pll_reset, sys_rst, locked_ok, fail, retry_cnt, loss_cnt
  );

endinterface

// File: rtl/pll_lock_sync.sv
// Multi-flop synchroniser bringing the asynchronous PLL lock into the reference clock domain.
// Output follows the input after STAGES clock edges; cleared by the synchronous reset.
module pll_lock_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk) begin
    if (reset) begin
      ff <= '0;
    end else begin
      ff <= {ff[STAGES-2:0], din};
    end
  end

  assign dout = ff[STAGES-1];

endmodule

// File: rtl/pll_lock_sequencer.sv
// Brings up a PLL from its reference clock: reset pulse, lock wait with timeout and bounded retries,
// stability qualification, then releases sys_rst; all outputs registered from the next state.
module pll_lock_sequencer
  import pll_ctrl_pkg::*;
#(
  parameter int RST_CYCLES    = 50,
  parameter int LOCK_TIMEOUT  = 50000,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRY     = 3,
  parameter int SYNC_STAGES   = 2
) (
  input logic                  clkin,
  input logic                  reset,
  pll_lock_sequencer_if.master bus
);

  localparam int CNT_MAX0 = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int CNT_MAX  = (CNT_MAX0 > STABLE_CYCLES) ? CNT_MAX0 : STABLE_CYCLES;
  localparam int CNT_W    = (clog2(CNT_MAX) < 1) ? 1 : clog2(CNT_MAX);
  localparam int RETRY_W  = (clog2(MAX_RETRY + 1) < 1) ? 1 : clog2(MAX_RETRY + 1);

  localparam logic [CNT_W-1:0]   RST_LAST   = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TMO_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   STB_LAST   = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(MAX_RETRY - 1);

  state_t             state;
  state_t             state_nx;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_nx;
  logic [RETRY_W-1:0] retry_q;
  logic [RETRY_W-1:0] retry_nx;
  logic [LOSS_W-1:0]  loss_q;
  logic [LOSS_W-1:0]  loss_nx;
  logic               lock_s;
  logic               attempt_fail;
  logic               pll_reset_q;
  logic               sys_rst_q;
  logic               locked_ok_q;
  logic               fail_q;

  pll_lock_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clkin),
    .reset (reset),
    .din   (bus.pll_lock),
    .dout  (lock_s)
  );

  always_comb begin
    state_nx     = state;
    retry_nx     = retry_q;
    loss_nx      = loss_q;
    attempt_fail = 1'b0;
    if (bus.restart) begin
      state_nx = ST_RESET_PLL;
      retry_nx = '0;
    end else begin
      case (state)
        ST_RESET_PLL: begin
          if (cnt == RST_LAST) state_nx = ST_WAIT_LOCK;
        end
        ST_WAIT_LOCK: begin
          if (lock_s) state_nx = ST_STABLE;
          else if (cnt == TMO_LAST) attempt_fail = 1'b1;
        end
        ST_STABLE: begin
          if (!lock_s) begin
            attempt_fail = 1'b1;
          end else if (cnt == STB_LAST) begin
            state_nx = ST_RUN;
            retry_nx = '0;
          end
        end
        ST_RUN: begin
          // Loss of lock in RUN is not a failed attempt: only the loss counter moves.
          if (!lock_s) begin
            state_nx = ST_RESET_PLL;
            if (loss_q != '1) loss_nx = loss_q + 1'b1;
          end
        end
        ST_FAIL: state_nx = ST_FAIL;
        default: state_nx = ST_RESET_PLL;
      endcase
      if (attempt_fail) begin
        retry_nx = retry_q + 1'b1;
        state_nx = (retry_q == RETRY_LAST) ? ST_FAIL : ST_RESET_PLL;
      end
    end
  end

  always_comb begin
    cnt_nx = '0;
    if (!bus.restart && (state_nx == state) &&
        ((state == ST_RESET_PLL) || (state == ST_WAIT_LOCK) || (state == ST_STABLE))) begin
      cnt_nx = cnt + 1'b1;
    end
  end

  always_ff @(posedge clkin) begin
    if (reset) begin
      state       <= ST_RESET_PLL;
      cnt         <= '0;
      retry_q     <= '0;
      loss_q      <= '0;
      pll_reset_q <= 1'b1;
      sys_rst_q   <= 1'b1;
      locked_ok_q <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      retry_q     <= retry_nx;
      loss_q      <= loss_nx;
      pll_reset_q <= (state_nx == ST_RESET_PLL) || (state_nx == ST_FAIL);
      sys_rst_q   <= (state_nx != ST_RUN);
      locked_ok_q <= (state_nx == ST_RUN);
      fail_q      <= (state_nx == ST_FAIL);
    end
  end

  always_ff @(posedge clkin) begin
    assert (MAX_RETRY >= 1 && SYNC_STAGES >= 2)
      else $error("pll_lock_sequencer: MAX_RETRY must be >= 1 and SYNC_STAGES >= 2");
  end

  assign bus.pll_reset = pll_reset_q;
  assign bus.sys_rst   = sys_rst_q;
  assign bus.locked_ok = locked_ok_q;
  assign bus.fail      = fail_q;
  assign bus.retry_cnt = retry_q;
  assign bus.loss_cnt  = loss_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer: expected output snapshots are queued with their due cycle
// when stimulus is applied and compared when that cycle's outputs are sampled, #1 after the edge.
module tb_pll_lock_sequencer;
  import pll_ctrl_pkg::*;

  localparam int RST_CYCLES    = 4;
  localparam int LOCK_TIMEOUT  = 16;
  localparam int STABLE_CYCLES = 8;
  localparam int MAX_RETRY     = 2;
  localparam int SYNC_STAGES   = 2;
  localparam int RETRY_W       = clog2(MAX_RETRY + 1);
  localparam int VW            = RETRY_W + LOSS_W + 4;

  typedef struct {
    int            due;
    string         tag;
    logic [VW-1:0] val;
  } exp_t;

  logic clkin;
  logic reset;
  int   cyc;
  int   checks;
  int   errors;
  exp_t sb[$];

  pll_lock_sequencer_if #(.RETRY_W(RETRY_W)) ifc ();

  pll_lock_sequencer #(
    .RST_CYCLES    (RST_CYCLES),
    .LOCK_TIMEOUT  (LOCK_TIMEOUT),
    .STABLE_CYCLES (STABLE_CYCLES),
    .MAX_RETRY     (MAX_RETRY),
    .SYNC_STAGES   (SYNC_STAGES)
  ) dut (
    .clkin (clkin),
    .reset (reset),
    .bus   (ifc.master)
  );

  initial begin
    clkin = 1'b0;
    forever #5 clkin = ~clkin;
  end

  // Snapshot order: pll_reset, sys_rst, locked_ok, fail, retry_cnt, loss_cnt.
  function automatic logic [VW-1:0] pack(input logic pr, input logic sr, input logic lo,
                                         input logic fl, input int rc, input int lc);
    return {pr, sr, lo, fl, RETRY_W'(rc), LOSS_W'(lc)};
  endfunction

  task automatic expect_at(input string tag, input int dly, input logic [VW-1:0] val);
    exp_t e;
    e.due = cyc + dly;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic check_due();
    logic [VW-1:0] obs;
    logic [VW-1:0] ev;
    int            idx;
    obs = {ifc.pll_reset, ifc.sys_rst, ifc.locked_ok, ifc.fail, ifc.retry_cnt, ifc.loss_cnt};
    idx = 0;
    while (idx < sb.size()) begin
      if (sb[idx].due == cyc) begin
        ev = sb[idx].val;
        checks++;
        assert (obs === ev) else begin
          errors++;
          $error("FAIL %s cyc=%0d observed pr,sr,ok,fail,retry,loss=%b,%b,%b,%b,%0d,%0d expected %b,%b,%b,%b,%0d,%0d",
                 sb[idx].tag, cyc,
                 obs[VW-1], obs[VW-2], obs[VW-3], obs[VW-4], obs[LOSS_W +: RETRY_W], obs[LOSS_W-1:0],
                 ev[VW-1], ev[VW-2], ev[VW-3], ev[VW-4], ev[LOSS_W +: RETRY_W], ev[LOSS_W-1:0]);
        end
        sb.delete(idx);
      end else begin
        idx++;
      end
    end
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clkin);
      #1;
      cyc++;
      check_due();
    end
  endtask

  initial begin
    cyc           = 0;
    checks        = 0;
    errors        = 0;
    reset         = 1'b1;
    ifc.pll_lock  = 1'b0;
    ifc.restart   = 1'b0;

    // Power-up reset, then two lock timeouts into FAIL.
    expect_at("por", 1, pack(1, 1, 0, 0, 0, 0));
    tick(3);
    reset = 1'b0;
    expect_at("rst_hold",          3,    pack(1, 1, 0, 0, 0, 0));
    expect_at("rst_release",       4,    pack(0, 1, 0, 0, 0, 0));
    expect_at("wait_last",         19,   pack(0, 1, 0, 0, 0, 0));
    expect_at("timeout1",          20,   pack(1, 1, 0, 0, 1, 0));
    expect_at("retry_rst_hold",    23,   pack(1, 1, 0, 0, 1, 0));
    expect_at("retry_rst_release", 24,   pack(0, 1, 0, 0, 1, 0));
    expect_at("wait2_last",        39,   pack(0, 1, 0, 0, 1, 0));
    expect_at("fail",              40,   pack(1, 1, 0, 1, 2, 0));
    expect_at("fail_held",         1040, pack(1, 1, 0, 1, 2, 0));
    tick(1040);

    // One-cycle restart out of FAIL, then a normal lock.
    ifc.restart = 1'b1;
    expect_at("restart",             1, pack(1, 1, 0, 0, 0, 0));
    expect_at("restart_rst_hold",    4, pack(1, 1, 0, 0, 0, 0));
    expect_at("restart_rst_release", 5, pack(0, 1, 0, 0, 0, 0));
    tick(1);
    ifc.restart = 1'b0;
    tick(7);
    ifc.pll_lock = 1'b1;
    expect_at("lock_sync",   2,  pack(0, 1, 0, 0, 0, 0));
    expect_at("stable_last", 10, pack(0, 1, 0, 0, 0, 0));
    expect_at("run",         11, pack(0, 0, 1, 0, 0, 0));
    tick(13);

    // Repeated one-cycle lock drops in RUN; loss counter saturates.
    for (int k = 1; k <= 300; k++) begin
      ifc.pll_lock = 1'b0;
      if (k == 1) begin
        expect_at("run_before_drop", 2, pack(0, 0, 1, 0, 0, 0));
        expect_at("loss1",           3, pack(1, 1, 0, 0, 0, 1));
      end
      expect_at("relock", 16, pack(0, 0, 1, 0, 0, (k > 255) ? 255 : k));
      tick(1);
      ifc.pll_lock = 1'b1;
      tick(16);
    end

    // Drop in STABLE while cnt=5 counts as a failed attempt; sys_rst stays high throughout.
    ifc.pll_lock = 1'b0;
    expect_at("loss_sat", 3, pack(1, 1, 0, 0, 0, 255));
    tick(7);
    ifc.pll_lock = 1'b1;
    tick(6);
    ifc.pll_lock = 1'b0;
    expect_at("stable_cnt5", 2, pack(0, 1, 0, 0, 0, 255));
    for (int k = 3; k <= 15; k++) begin
      expect_at("no_release", k, pack(k < 7, 1, 0, 0, 1, 255));
    end
    expect_at("relock_clr", 16, pack(0, 0, 1, 0, 0, 255));
    tick(3);
    ifc.pll_lock = 1'b1;
    tick(13);

    // reset and restart together: reset wins, loss counter cleared.
    reset       = 1'b1;
    ifc.restart = 1'b1;
    expect_at("reset_and_restart", 1, pack(1, 1, 0, 0, 0, 0));
    tick(1);
    reset       = 1'b0;
    ifc.restart = 1'b0;
    expect_at("mid_rst_hold",    3, pack(1, 1, 0, 0, 0, 0));
    expect_at("mid_rst_release", 4, pack(0, 1, 0, 0, 0, 0));
    tick(4);

    // restart held for 6 cycles keeps cnt at 0; full reset pulse follows release.
    ifc.restart = 1'b1;
    expect_at("restart_held",         6,  pack(1, 1, 0, 0, 0, 0));
    expect_at("restart_held_tail",    9,  pack(1, 1, 0, 0, 0, 0));
    expect_at("restart_held_release", 10, pack(0, 1, 0, 0, 0, 0));
    tick(6);
    ifc.restart = 1'b0;
    tick(6);

    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL sb_drain observed %0d pending expected 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
